// File: rtl/mem_if.sv
// mem_if: CPU memory-port bundle between a requester (CPU) and a responder.
//   enable     : request strobe (master -> slave)
//   wr         : 1 = write, 0 = read (master -> slave)
//   addr       : 16-bit byte address (master -> slave)
//   data_in    : write data (master -> slave)
//   data_out   : registered read data (slave -> master)
//   data_valid : one-cycle pulse, data_out holds a completed read (slave -> master)
//   busy       : request in flight, requester must stall (slave -> master)
interface mem_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: responder side of the CPU instruction/data memory port,
// modelling a memory with a fixed request-to-response latency.
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset (array contents are preserved)
//   bus : mem_if.slave -- enable/wr/addr/data_in in, data_out/data_valid/busy out
// Parameters:
//   ADDR_W  : word-index width (2^ADDR_W 16-bit words), word index = addr[ADDR_W:1];
//             must be 14 or less so that at least one upper address bit is dropped
//   LATENCY : cycles from acceptance to data_valid, 2..15
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input logic   clk,
  input logic   rst,
  mem_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                capture;
  logic                complete;

  // Request fields are latched at acceptance and held for the whole
  // BUSY period, so the bus may change freely while we work.
  logic                wr_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [15:0]         wdata_reg;

  logic [15:0]         data_out_reg;
  logic                data_valid_reg;

  logic [15:0]         mem [DEPTH];

  // Byte-select bit and high address bits are intentionally dropped,
  // which is what makes out-of-range addresses alias.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[15:ADDR_W+1], bus.addr[0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable) begin
          capture    = 1'b1;
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 4'd1;
        // Completing when the counter reads 1 puts data_valid in the
        // cycle exactly LATENCY cycles after acceptance.
        if (cnt_reg == 4'd1) begin
          state_next = IDLE;
          complete   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= 16'h0000;
      data_out_reg   <= 16'h0000;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      data_valid_reg <= complete && !wr_reg;
      if (capture) begin
        wr_reg    <= bus.wr;
        addr_reg  <= bus.addr[ADDR_W:1];
        wdata_reg <= bus.data_in;
      end
      if (complete && !wr_reg) begin
        data_out_reg <= mem[addr_reg];
      end
    end
  end

  // Array has no reset so preloaded images survive rst. An aborted
  // request never reaches completion because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (complete && wr_reg) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

  assign bus.busy       = (state_reg == BUSY);
  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Two instances: dut4 (LATENCY=4) for the main scenarios and dut2
// (LATENCY=2) for the minimum-latency corner. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_if b4 ();
  mem_if b2 ();

  mem_responder #(.ADDR_W(10), .LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mem_responder #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

  int          cmp_count = 0;
  int          err_count = 0;

  int          busy_cnt;
  int          dv_cnt;
  int          dv_idx;
  logic [15:0] dv_data;

  // Drive one request on b4 and observe a fixed 6-cycle window.
  // dv_idx is the falling edge (1-based, after acceptance) where data_valid was seen.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    b4.enable = 1'b1; b4.wr = w; b4.addr = a; b4.data_in = d;
    busy_cnt = 0; dv_cnt = 0; dv_idx = 0; dv_data = 16'h0000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) b4.enable = 1'b0;
      if (b4.busy) busy_cnt++;
      if (b4.data_valid) begin
        dv_cnt++;
        dv_idx  = k;
        dv_data = b4.data_out;
      end
    end
    $display("req wr=%0b addr=%h din=%h : busy_cycles=%0d dv_count=%0d dv_at=%0d dout=%h",
             w, a, d, busy_cnt, dv_cnt, dv_idx, dv_data);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b4.enable = 1'b0; b4.wr = 1'b0; b4.addr = 16'h0000; b4.data_in = 16'h0000;
    b2.enable = 1'b0; b2.wr = 1'b0; b2.addr = 16'h0000; b2.data_in = 16'h0000;
    repeat (3) @(negedge clk);
    cmp_count++; if (b4.busy !== 1'b0) begin err_count++; $display("FAIL rst_busy4: got %b want 0", b4.busy); end
    cmp_count++; if (b4.data_valid !== 1'b0) begin err_count++; $display("FAIL rst_dv4: got %b want 0", b4.data_valid); end
    cmp_count++; if (b4.data_out !== 16'h0000) begin err_count++; $display("FAIL rst_dout4: got %h want 0000", b4.data_out); end
    cmp_count++; if (b2.busy !== 1'b0) begin err_count++; $display("FAIL rst_busy2: got %b want 0", b2.busy); end
    cmp_count++; if (b2.data_valid !== 1'b0) begin err_count++; $display("FAIL rst_dv2: got %b want 0", b2.data_valid); end
    cmp_count++; if (b2.data_out !== 16'h0000) begin err_count++; $display("FAIL rst_dout2: got %h want 0000", b2.data_out); end
    // Request presented together with reset release: first edge must accept it.
    rst = 1'b0;
    b4.enable = 1'b1; b4.wr = 1'b1; b4.addr = 16'h0040; b4.data_in = 16'h7777;
    @(negedge clk);
    b4.enable = 1'b0;
    cmp_count++; if (b4.busy !== 1'b1) begin err_count++; $display("FAIL first_edge_accept: busy got %b want 1", b4.busy); end
    $display("req wr=1 addr=0040 din=7777 : accepted on first edge after reset");
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read;
    do_req(1'b1, 16'h0010, 16'hBEEF);
    cmp_count++; if (busy_cnt != 3) begin err_count++; $display("FAIL wr_busy_cycles: got %0d want 3", busy_cnt); end
    cmp_count++; if (dv_cnt != 0) begin err_count++; $display("FAIL wr_no_dv: got %0d pulses want 0", dv_cnt); end
    do_req(1'b0, 16'h0010, 16'h0000);
    cmp_count++; if (busy_cnt != 3) begin err_count++; $display("FAIL rd_busy_cycles: got %0d want 3", busy_cnt); end
    cmp_count++; if (dv_cnt != 1) begin err_count++; $display("FAIL rd_dv_count: got %0d want 1", dv_cnt); end
    cmp_count++; if (dv_idx != 4) begin err_count++; $display("FAIL rd_dv_latency: got %0d want 4", dv_idx); end
    cmp_count++; if (dv_data !== 16'hBEEF) begin err_count++; $display("FAIL rd_data: got %h want BEEF", dv_data); end
    // A write must not disturb data_out.
    do_req(1'b1, 16'h0012, 16'h1111);
    cmp_count++; if (b4.data_out !== 16'hBEEF) begin err_count++; $display("FAIL dout_hold_after_wr: got %h want BEEF", b4.data_out); end
  endtask

  task automatic test_ignored;
    do_req(1'b1, 16'h0020, 16'hCAFE);
    @(negedge clk);
    b4.enable = 1'b1; b4.wr = 1'b0; b4.addr = 16'h0010; b4.data_in = 16'h0000;
    dv_cnt = 0; dv_idx = 0; dv_data = 16'h0000;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        // Hammer the bus while busy: these must all be dropped.
        b4.wr = 1'b1; b4.addr = 16'h0020; b4.data_in = 16'hDEAD;
      end
      if (b4.data_valid) begin
        dv_cnt++; dv_idx = k; dv_data = b4.data_out;
      end
      if (k == 4) b4.enable = 1'b0;
    end
    $display("req wr=0 addr=0010 with ignored traffic : dv_count=%0d dv_at=%0d dout=%h", dv_cnt, dv_idx, dv_data);
    cmp_count++; if (dv_cnt != 1) begin err_count++; $display("FAIL ign_dv_count: got %0d want 1", dv_cnt); end
    cmp_count++; if (dv_idx != 4) begin err_count++; $display("FAIL ign_dv_latency: got %0d want 4", dv_idx); end
    cmp_count++; if (dv_data !== 16'hBEEF) begin err_count++; $display("FAIL ign_rd_data: got %h want BEEF", dv_data); end
    do_req(1'b0, 16'h0020, 16'h0000);
    cmp_count++; if (dv_data !== 16'hCAFE) begin err_count++; $display("FAIL ign_no_write: got %h want CAFE", dv_data); end
  endtask

  task automatic test_back_to_back;
    int          first_idx, second_idx, n_dv;
    logic [15:0] d1, d2;
    logic        busy_k5;
    first_idx = 0; second_idx = 0; n_dv = 0; d1 = 16'h0000; d2 = 16'h0000; busy_k5 = 1'b0;
    @(negedge clk);
    b4.enable = 1'b1; b4.wr = 1'b0; b4.addr = 16'h0010; b4.data_in = 16'h0000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) b4.enable = 1'b0;
      if (k == 5) busy_k5 = b4.busy;
      if (b4.data_valid) begin
        n_dv++;
        if (first_idx == 0) begin first_idx = k; d1 = b4.data_out; end
        else begin second_idx = k; d2 = b4.data_out; end
      end
      if (k == 4) begin
        b4.enable = 1'b1; b4.wr = 1'b0; b4.addr = 16'h0020;
      end
      if (k == 5) b4.enable = 1'b0;
    end
    $display("b2b reads 0010,0020 : dv_at=%0d,%0d dout=%h,%h", first_idx, second_idx, d1, d2);
    cmp_count++; if (n_dv != 2) begin err_count++; $display("FAIL b2b_dv_count: got %0d want 2", n_dv); end
    cmp_count++; if (first_idx != 4) begin err_count++; $display("FAIL b2b_first_at: got %0d want 4", first_idx); end
    cmp_count++; if (second_idx != 8) begin err_count++; $display("FAIL b2b_second_at: got %0d want 8", second_idx); end
    cmp_count++; if (busy_k5 !== 1'b1) begin err_count++; $display("FAIL b2b_accepted: busy got %b want 1", busy_k5); end
    cmp_count++; if (d1 !== 16'hBEEF) begin err_count++; $display("FAIL b2b_data1: got %h want BEEF", d1); end
    cmp_count++; if (d2 !== 16'hCAFE) begin err_count++; $display("FAIL b2b_data2: got %h want CAFE", d2); end
  endtask

  task automatic test_reset_abort;
    int n_dv;
    n_dv = 0;
    @(negedge clk);
    b4.enable = 1'b1; b4.wr = 1'b1; b4.addr = 16'h0040; b4.data_in = 16'h1234;
    @(negedge clk);
    b4.enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp_count++; if (b4.busy !== 1'b0) begin err_count++; $display("FAIL abort_busy: got %b want 0", b4.busy); end
    cmp_count++; if (b4.data_valid !== 1'b0) begin err_count++; $display("FAIL abort_dv: got %b want 0", b4.data_valid); end
    cmp_count++; if (b4.data_out !== 16'h0000) begin err_count++; $display("FAIL abort_dout: got %h want 0000", b4.data_out); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (b4.data_valid) n_dv++;
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (b4.data_valid) n_dv++;
    end
    $display("req wr=1 addr=0040 din=1234 : aborted by reset, dv_count=%0d", n_dv);
    cmp_count++; if (n_dv != 0) begin err_count++; $display("FAIL abort_no_pulse: got %0d want 0", n_dv); end
    do_req(1'b0, 16'h0040, 16'h0000);
    cmp_count++; if (dv_data !== 16'h7777) begin err_count++; $display("FAIL abort_no_write: got %h want 7777", dv_data); end
  endtask

  task automatic test_alias;
    do_req(1'b1, 16'h0801, 16'h5A5A);
    do_req(1'b0, 16'h0000, 16'h0000);
    cmp_count++; if (dv_data !== 16'h5A5A) begin err_count++; $display("FAIL alias_data: got %h want 5A5A", dv_data); end
    cmp_count++; if (dv_idx != 4) begin err_count++; $display("FAIL alias_dv_at: got %0d want 4", dv_idx); end
  endtask

  task automatic test_latency2;
    int          b_cnt, b_idx, v_cnt, v_idx;
    logic [15:0] v_data;
    for (int pass = 0; pass < 2; pass++) begin
      b_cnt = 0; b_idx = 0; v_cnt = 0; v_idx = 0; v_data = 16'h0000;
      @(negedge clk);
      b2.enable = 1'b1; b2.wr = (pass == 0); b2.addr = 16'h0006;
      b2.data_in = (pass == 0) ? 16'h0BAD : 16'h0000;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) b2.enable = 1'b0;
        if (b2.busy) begin b_cnt++; b_idx = k; end
        if (b2.data_valid) begin v_cnt++; v_idx = k; v_data = b2.data_out; end
      end
      $display("L2 req wr=%0b addr=0006 : busy_cycles=%0d busy_at=%0d dv_count=%0d dv_at=%0d dout=%h",
               (pass == 0), b_cnt, b_idx, v_cnt, v_idx, v_data);
      cmp_count++; if (b_cnt != 1) begin err_count++; $display("FAIL l2_busy_cycles: got %0d want 1", b_cnt); end
      if (pass == 0) begin
        cmp_count++; if (v_cnt != 0) begin err_count++; $display("FAIL l2_wr_no_dv: got %0d want 0", v_cnt); end
      end else begin
        cmp_count++; if (b_idx != 1) begin err_count++; $display("FAIL l2_busy_at: got %0d want 1", b_idx); end
        cmp_count++; if (v_cnt != 1) begin err_count++; $display("FAIL l2_dv_count: got %0d want 1", v_cnt); end
        cmp_count++; if (v_idx != 2) begin err_count++; $display("FAIL l2_dv_at: got %0d want 2", v_idx); end
        cmp_count++; if (v_data !== 16'h0BAD) begin err_count++; $display("FAIL l2_data: got %h want 0BAD", v_data); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_ignored;
    test_back_to_back;
    test_reset_abort;
    test_alias;
    test_latency2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
